// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and memory-access stages.
// Ports:
//   clk, rst (async, active-low), flush      - clock, reset, front-end flush
//   fetchReq/fetchAddr -> fetchGrant/Valid/Data   - instruction read port
//   maReq/maWe/maAddr/maWdata/maBe -> maGrant/Valid/Rdata - data load/store port
//   isStructureStall                          - holds fetch while its access is pending
//   memReady/memRvalid/memRdata <-> memReq/memWe/memAddr/memWdata/memBe - memory side
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                fetchReq,
    input  logic [ADDR_W-1:0]   fetchAddr,
    output logic                fetchGrant,
    output logic                fetchValid,
    output logic [DATA_W-1:0]   fetchData,
    input  logic                maReq,
    input  logic                maWe,
    input  logic [ADDR_W-1:0]   maAddr,
    input  logic [DATA_W-1:0]   maWdata,
    input  logic [DATA_W/8-1:0] maBe,
    output logic                maGrant,
    output logic                maValid,
    output logic [DATA_W-1:0]   maRdata,
    output logic                isStructureStall,
    input  logic                memReady,
    output logic                memReq,
    output logic                memWe,
    output logic [ADDR_W-1:0]   memAddr,
    output logic [DATA_W-1:0]   memWdata,
    output logic [DATA_W/8-1:0] memBe,
    input  logic                memRvalid,
    input  logic [DATA_W-1:0]   memRdata
);
    typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_M} state_t;
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t              state_q;
    logic                drop_q;
    logic                we_q;
    logic [3:0]          starve_q;
    logic                fetch_valid_q;
    logic                ma_valid_q;
    logic [DATA_W-1:0]   fetch_data_q;
    logic [DATA_W-1:0]   ma_rdata_q;
    logic                f_elig;
    logic                arb;
    logic                f_win;
    logic                m_win;
    assign f_elig = fetchReq & ~flush;
    assign arb    = (state_q == IDLE) & memReady;
    // A fetch whose data is being delivered this cycle may not start a second access.
    assign f_win  = arb & f_elig & ~fetch_valid_q & (~maReq | (starve_q == LIM));
    assign m_win  = arb & maReq & ~f_win;
    assign fetchGrant       = f_win;
    assign maGrant          = m_win;
    assign memReq           = f_win | m_win;
    assign memWe            = m_win & maWe;
    assign memAddr          = m_win ? maAddr : fetchAddr;
    assign memWdata         = m_win ? maWdata : '0;
    assign memBe            = m_win ? maBe : '1;
    assign isStructureStall = fetchReq & ~fetch_valid_q & ~flush;
    assign fetchValid       = fetch_valid_q;
    assign fetchData        = fetch_data_q;
    assign maValid          = ma_valid_q;
    assign maRdata          = ma_rdata_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            drop_q        <= 1'b0;
            we_q          <= 1'b0;
            starve_q      <= '0;
            fetch_valid_q <= 1'b0;
            ma_valid_q    <= 1'b0;
            fetch_data_q  <= '0;
            ma_rdata_q    <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            ma_valid_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (f_win) begin
                        state_q  <= WAIT_F;
                        starve_q <= '0;
                    end else if (m_win) begin
                        state_q <= WAIT_M;
                        we_q    <= maWe;
                        if (f_elig && starve_q != LIM) starve_q <= starve_q + 4'd1;
                    end
                end
                WAIT_F: begin
                    if (memRvalid) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        // A flush in the response cycle discards the data just like an earlier one.
                        if (!(drop_q || flush)) begin
                            fetch_valid_q <= 1'b1;
                            fetch_data_q  <= memRdata;
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end
                end
                WAIT_M: begin
                    if (memRvalid) begin
                        state_q    <= IDLE;
                        ma_valid_q <= 1'b1;
                        ma_rdata_q <= we_q ? '0 : memRdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench comparing mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            fetchReq = 1'b0;
    logic [AW-1:0]   fetchAddr = '0;
    logic            fetchGrant;
    logic            fetchValid;
    logic [DW-1:0]   fetchData;
    logic            maReq = 1'b0;
    logic            maWe = 1'b0;
    logic [AW-1:0]   maAddr = '0;
    logic [DW-1:0]   maWdata = '0;
    logic [DW/8-1:0] maBe = '0;
    logic            maGrant;
    logic            maValid;
    logic [DW-1:0]   maRdata;
    logic            isStructureStall;
    logic            memReady = 1'b0;
    logic            memReq;
    logic            memWe;
    logic [AW-1:0]   memAddr;
    logic [DW-1:0]   memWdata;
    logic [DW/8-1:0] memBe;
    logic            memRvalid = 1'b0;
    logic [DW-1:0]   memRdata = '0;
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchGrant(fetchGrant),
        .fetchValid(fetchValid), .fetchData(fetchData),
        .maReq(maReq), .maWe(maWe), .maAddr(maAddr), .maWdata(maWdata), .maBe(maBe),
        .maGrant(maGrant), .maValid(maValid), .maRdata(maRdata),
        .isStructureStall(isStructureStall),
        .memReady(memReady), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memBe(memBe), .memRvalid(memRvalid), .memRdata(memRdata)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Transaction-level model: who owns the memory, whether its result is discarded,
    // how many fetch losses in a row, and what the result ports should show.
    int            owner = 0;
    bit            is_store = 0;
    bit            discard = 0;
    int            losses = 0;
    bit            e_fv = 0;
    bit            e_mv = 0;
    logic [DW-1:0] e_fd = '0;
    logic [DW-1:0] e_md = '0;
    int            mem_cnt = 0;
    bit            gF = 0;
    bit            gM = 0;
    int            resets = 0;
    task automatic model_reset();
        owner = 0; discard = 0; losses = 0;
        e_fv = 0; e_mv = 0; e_fd = '0; e_md = '0;
        gF = 0; gM = 0;
    endtask
    task automatic check_regs(input string pfx);
        check({pfx, "_fetchValid"}, fetchValid, e_fv);
        check({pfx, "_fetchData"}, fetchData, e_fd);
        check({pfx, "_maValid"}, maValid, e_mv);
        check({pfx, "_maRdata"}, maRdata, e_md);
    endtask
    task automatic drive();
        if (gF || !fetchReq) begin
            fetchReq  = ($urandom % 4) != 0;
            fetchAddr = $urandom & ~32'h3;
        end
        if (gM || !maReq) begin
            maReq   = ($urandom % 4) != 0;
            maWe    = $urandom % 2;
            maAddr  = $urandom & ~32'h3;
            maWdata = $urandom;
            maBe    = 4'($urandom);
        end
        flush     = ($urandom % 8) == 0;
        memReady  = (mem_cnt == 0) && (($urandom % 5) != 0);
        memRvalid = mem_cnt == 1;
        memRdata  = $urandom;
    endtask
    task automatic check_and_step();
        bit f_ok, m_ok, eF, eM, nfv, nmv;
        f_ok = fetchReq && !flush;
        m_ok = maReq;
        eF = (owner == 0) && memReady && f_ok && !e_fv && (!m_ok || losses == LIM);
        eM = (owner == 0) && memReady && m_ok && !eF;
        check("fetchGrant", fetchGrant, eF);
        check("maGrant", maGrant, eM);
        check("memReq", memReq, eF || eM);
        if (eF || eM) begin
            check("memWe", memWe, eM && maWe);
            check("memAddr", memAddr, eM ? maAddr : fetchAddr);
            check("memWdata", memWdata, eM ? maWdata : 32'h0);
            check("memBe", memBe, eM ? maBe : 4'hf);
        end
        check("stall", isStructureStall, fetchReq && !e_fv && !flush);
        check_regs("run");
        nfv = 0;
        nmv = 0;
        if (owner != 0 && memRvalid) begin
            if (owner == 1 && !(discard || flush)) begin
                nfv = 1;
                e_fd = memRdata;
            end
            if (owner == 2) begin
                nmv = 1;
                e_md = is_store ? '0 : memRdata;
            end
            owner = 0;
            discard = 0;
        end else if (owner == 1 && flush) begin
            discard = 1;
        end
        if (eF) begin
            owner = 1;
            losses = 0;
        end
        if (eM) begin
            owner = 2;
            is_store = maWe;
            if (f_ok) losses = (losses < LIM) ? losses + 1 : LIM;
        end
        e_fv = nfv;
        e_mv = nmv;
        if (mem_cnt > 0) mem_cnt--;
        if (eF || eM) mem_cnt = $urandom_range(1, 3);
        gF = eF;
        gM = eM;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        check("reset_memReq", memReq, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            drive();
            if (owner == 2 && resets < 40 && ($urandom % 32) == 0) begin
                memReady = 1'b0;
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_regs("async_rst");
                check("async_rst_memReq", memReq, 1'b0);
                if (mem_cnt > 0) mem_cnt--;
                resets++;
                @(posedge clk);
                #1;
                check_regs("in_rst");
                rst = 1'b1;
            end else begin
                #1;
                check_and_step();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory-access stage (data loads/stores).
- Allows at most one outstanding memory transaction at a time.
- Gives data accesses priority, with a starvation guard for fetch.
- Drives the structure-stall indication that holds fetch while its access is pending, and discards in-flight fetch data when a branch mispredict flushes the front end.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enable is DATA_W/8 bits)
- STARVE_LIMIT, 4, consecutive fetch losses before fetch wins the next arbitration (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- flush  in  1  branch-predict-miss flush of the fetch path
- fetchReq  in  1  fetch requests a read
- fetchAddr  in  ADDR_W  fetch read address
- fetchGrant  out  1  fetch request accepted this cycle
- fetchValid  out  1  one-cycle pulse, fetchData valid
- fetchData  out  DATA_W  instruction word
- maReq  in  1  memory-access request
- maWe  in  1  1 = store, 0 = load
- maAddr  in  ADDR_W  data address
- maWdata  in  DATA_W  store data
- maBe  in  DATA_W/8  store byte enables
- maGrant  out  1  MA request accepted this cycle
- maValid  out  1  one-cycle pulse, load data valid or store complete
- maRdata  out  DATA_W  load data (0 for stores)
- isStructureStall  out  1  fetch must hold PC and pipe register
- memReady  in  1  memory can accept a request
- memReq  out  1  request to memory
- memWe, memAddr, memWdata, memBe  out  1/ADDR_W/DATA_W/DATA_W/8  request fields
- memRvalid  in  1  response/ack for the outstanding request
- memRdata  in  DATA_W  read data, valid with memRvalid

Behaviour:
- States: IDLE, WAIT_F (fetch outstanding), WAIT_M (MA outstanding).
- Reset values: state = IDLE, drop = 0, starveCnt = 0. All registered outputs are 0: fetchValid, fetchData, maValid, maRdata.
- Reset is legal mid-transaction. A late memRvalid arriving in IDLE is ignored.
- Arbitration happens in IDLE only, combinationally in the cycle memReady = 1:
  - Fetch is eligible when fetchReq = 1 and flush = 0.
  - If both MA and fetch are eligible: MA wins unless starveCnt == STARVE_LIMIT, in which case fetch wins.
  - If only one is eligible, it wins.
- Grant cycle:
  - The grant output is 1 and memReq = 1, with the mem* fields muxed from the winner.
  - For fetch grants: memWe = 0, memBe = all ones, memWdata = 0.
  - At the clock edge the state moves to WAIT_F or WAIT_M.
- In WAIT_x or with memReady = 0: memReq = 0, no grants, requesters must hold their request and fields.
- Response: memRvalid in WAIT_x registers memRdata into fetchData or maRdata (maRdata = 0 for stores). The matching valid output pulses for exactly the next cycle, and the state returns to IDLE on the same edge.
- Minimum latency: grant at T, memRvalid at T+1, valid at T+2. A new arbitration is possible at T+2.
- starveCnt:
  - Increments, saturating at STARVE_LIMIT, on each grant to MA while fetch is eligible.
  - Clears to 0 on any fetch grant.
  - Is unchanged otherwise.
- Flush:
  - In WAIT_F, or in the same cycle memRvalid arrives in WAIT_F: set drop = 1. The response is consumed, fetchValid stays 0, and fetchData is not updated.
  - drop clears on return to IDLE.
  - In IDLE, flush masks fetchReq for that cycle.
  - Flush never affects MA transactions.
- isStructureStall = fetchReq & ~fetchValid & ~flush. It is combinational, and high through the grant and wait cycles including loss to MA.
- While fetchValid = 1, a new fetchReq in the same cycle must not be granted; the first eligible cycle is the next one. This keeps one access per fetch handshake.
- A simultaneous fetchReq and maReq with memReady = 0 produces no grant, and starveCnt is unchanged.

Test Plan:
- Single fetch, memory responds 1 cycle after grant, addr 0x100, data 0x00000013 -> fetchGrant at T, memReq/memAddr = 0x100 at T, fetchValid = 1 with fetchData = 0x13 at T+2, isStructureStall high T..T+1 and low at T+2.
- Continuous fetchReq and maReq, STARVE_LIMIT = 4 -> MA granted 4 times, then fetch granted on the 5th arbitration, starveCnt back to 0, and the pattern repeats.
- MA store addr 0x2000, wdata 0xDEADBEEF, be 0b0011 -> memWe = 1, memBe = 0b0011 on the grant cycle, maValid pulse with maRdata = 0, no fetchValid.
- Fetch outstanding, flush asserted for one cycle in WAIT_F, memRvalid 3 cycles later -> fetchValid never asserts, state back to IDLE, next fetchReq granted.
- memReady held 0 for 5 cycles with both requests -> memReq = 0, no grants, starveCnt unchanged; then memReady = 1 -> MA granted.
- rst asserted asynchronously mid-WAIT_M, then memRvalid after release -> all outputs 0, no maValid, arbiter grants normally afterwards.
